// File: rtl/bcd_scan_ctrl.sv
// bcd_scan_ctrl
//
// Purpose:
//   Steps through a packed multi-digit BCD word, one digit at a time, and
//   presents each digit on the A1/A2/A4/A8 inputs of a shared `bcd`
//   BCD-to-decimal decoder. A one-hot digit select accompanies each digit.
//   Each digit is held for DWELL cycles, with GAP blank cycles between digits.
//   Codes above 9 are blanked on the decoder inputs and raise err.
//
// Parameters:
//   NDIG   number of BCD digits per word (>= 1)
//   DWELL  cycles each digit is presented (>= 1)
//   GAP    blank cycles between consecutive digits (>= 0)
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   in_valid  in_bcd holds a word to display
//   in_ready  controller can accept a word
//   in_bcd    packed BCD word, digit i = in_bcd[4i+3:4i], digit 0 shown first
//   abort     synchronous frame cancel
//   dec_a1    decoder input A1 (digit bit 0)
//   dec_a2    decoder input A2 (digit bit 1)
//   dec_a4    decoder input A4 (digit bit 2)
//   dec_a8    decoder input A8 (digit bit 3)
//   dig_sel   one-hot digit enable, all zero while blank
//   busy      frame in progress
//   done      one-cycle pulse at frame completion
//   err       an invalid digit was seen in the current/last frame
module bcd_scan_ctrl #(
  parameter int NDIG  = 4,
  parameter int DWELL = 8,
  parameter int GAP   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] in_bcd,
  input  logic              abort,
  output logic              dec_a1,
  output logic              dec_a2,
  output logic              dec_a4,
  output logic              dec_a8,
  output logic [NDIG-1:0]   dig_sel,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CMAX = (DWELL > GAP) ? DWELL : GAP;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHOW,
    S_GAP,
    S_DONE
  } state_t;

  state_t            state, state_nx;
  logic [IW-1:0]     idx, idx_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [4*NDIG-1:0] shadow, shadow_nx;
  logic              new_digit;
  logic              clear_err;

  logic [3:0]        digit_nx;
  logic [3:0]        dec_nx;
  logic [3:0]        dec_q;
  logic [NDIG-1:0]   sel_nx;
  logic              ready_nx;
  logic              busy_nx;
  logic              done_nx;
  logic              err_nx;

  // Next-state logic. cnt counts cycles spent in the current SHOW or GAP
  // stretch and restarts at zero on every state change. new_digit marks the
  // transition into the first SHOW cycle of a digit, which is where an
  // invalid code gets flagged.
  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    cnt_nx    = cnt;
    shadow_nx = shadow;
    new_digit = 1'b0;
    clear_err = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid && !abort) begin
          shadow_nx = in_bcd;
          idx_nx    = '0;
          cnt_nx    = '0;
          state_nx  = S_SHOW;
          new_digit = 1'b1;
          clear_err = 1'b1;
        end
      end
      S_SHOW: begin
        if (abort) begin
          cnt_nx   = '0;
          state_nx = S_IDLE;
        end else if (cnt == DWELL_LAST) begin
          cnt_nx = '0;
          if (idx == IDX_LAST) begin
            state_nx = S_DONE;
          end else if (GAP > 0) begin
            state_nx = S_GAP;
          end else begin
            idx_nx    = idx + 1'b1;
            new_digit = 1'b1;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (abort) begin
          cnt_nx   = '0;
          state_nx = S_IDLE;
        end else if (cnt == GAP_LAST) begin
          cnt_nx    = '0;
          idx_nx    = idx + 1'b1;
          state_nx  = S_SHOW;
          new_digit = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_DONE: begin
        cnt_nx   = '0;
        state_nx = S_IDLE;
      end
      default: begin
        cnt_nx   = '0;
        state_nx = S_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so that every output can be
  // registered and still line up with the state it belongs to. The digit
  // mux walks the word instead of using a variable part-select so that an
  // idx value beyond NDIG-1 can never address past the word.
  always_comb begin
    digit_nx = 4'd0;
    sel_nx   = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx_nx == IW'(i)) begin
        digit_nx = shadow_nx[4*i +: 4];
      end
    end
    if (state_nx == S_SHOW) begin
      for (int i = 0; i < NDIG; i++) begin
        sel_nx[i] = (idx_nx == IW'(i));
      end
    end

    dec_nx   = ((state_nx == S_SHOW) && (digit_nx <= 4'd9)) ? digit_nx : 4'd0;
    ready_nx = (state_nx == S_IDLE);
    busy_nx  = (state_nx == S_SHOW) || (state_nx == S_GAP);
    done_nx  = (state_nx == S_DONE);

    // err is sticky until the next accepted word; on acceptance it is
    // cleared and then immediately re-raised if digit 0 is already invalid.
    err_nx = clear_err ? 1'b0 : err;
    if (new_digit && (digit_nx > 4'd9)) begin
      err_nx = 1'b1;
    end
  end

  // State, sequencing counters, and the captured word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      idx    <= '0;
      cnt    <= '0;
      shadow <= '0;
    end else begin
      state  <= state_nx;
      idx    <= idx_nx;
      cnt    <= cnt_nx;
      shadow <= shadow_nx;
    end
  end

  // Output registers; reset blanks the display immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready <= 1'b1;
      dec_q    <= 4'd0;
      dig_sel  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      in_ready <= ready_nx;
      dec_q    <= dec_nx;
      dig_sel  <= sel_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      err      <= err_nx;
    end
  end

  assign dec_a1 = dec_q[0];
  assign dec_a2 = dec_q[1];
  assign dec_a4 = dec_q[2];
  assign dec_a8 = dec_q[3];

endmodule
